// File: rtl/tdm_pkg.sv
// Shared types and constants for the four-lane TDM demultiplexer.
// Frame length grows to five slots when TDM_DEMUX_PARITY_EN is defined.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int LANES  = 4;
    localparam int ADDR_W = 3;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int SLOTS = 5;
`else
    localparam int SLOTS = 4;
`endif

endpackage

// File: rtl/tdm_lane_shifter.sv
// One lane deserializer: WIDTH-bit MSB-first shift register with clear.
// Latency: 1 cycle per shifted bit. No backpressure; shifts whenever en is high.
// Clear and shift in the same cycle leaves only the new bit (start of a fresh word).
module tdm_lane_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] base;

    always_comb base = clr ? '0 : q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= {base[WIDTH-2:0], d};
        end else if (clr) begin
            q <= '0;
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// Four-lane TDM demultiplexer/deserializer; optional parity slot via TDM_DEMUX_PARITY_EN.
// Latency: 1 cycle from the final beat of the WIDTH-th frame to Word/Word_valid.
// Backpressure: none; a valid beat is accepted every cycle.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    din,
    input  logic                    din_valid,
    input  logic                    sync,
    output logic [ADDR_W-1:0]       address,
    output logic [LANES-1:0]        lane,
    output logic [LANES*WIDTH-1:0]  word,
    output logic                    word_valid,
    output logic                    locked,
`ifdef TDM_DEMUX_PARITY_EN
    output logic                    parity_err,
`endif
    output logic                    sync_err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(SLOTS - 1);

    state_t                 state;
    logic [CW-1:0]          fcnt;
    logic                   take;
    logic                   clr_all;
    logic                   early;
    logic                   missing;
    logic [ADDR_W-1:0]      slot;
    logic [LANES-1:0]       sh_en;
    logic [WIDTH-1:0]       sh_q [LANES];
    logic [LANES*WIDTH-1:0] word_nxt;

    // Beat classification; slot is where a data bit lands (0 on any sync restart).
    always_comb begin
        take    = 1'b0;
        clr_all = 1'b0;
        early   = 1'b0;
        missing = 1'b0;
        if (din_valid) begin
            if (state == HUNT) begin
                take = sync;
            end else if (sync && address != '0) begin
                early   = 1'b1;
                take    = 1'b1;
                clr_all = 1'b1;
            end else if (!sync && address == '0) begin
                missing = 1'b1;
                clr_all = 1'b1;
            end else begin
                take = (address < ADDR_W'(LANES));
            end
        end
        slot = (early || state == HUNT) ? '0 : address;
    end

    // word_nxt folds in the bit being shifted this cycle so completion needs no extra beat.
    always_comb begin
        sh_en    = '0;
        word_nxt = '0;
        for (int k = 0; k < LANES; k++) begin
            sh_en[k] = take && (slot == ADDR_W'(k));
            word_nxt[k*WIDTH +: WIDTH] = sh_en[k] ? {sh_q[k][WIDTH-2:0], din} : sh_q[k];
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        tdm_lane_shifter #(.WIDTH(WIDTH)) u_shift (
            .clock (clock),
            .reset (reset),
            .en    (sh_en[k]),
            .clr   (clr_all),
            .d     (din),
            .q     (sh_q[k])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= HUNT;
            address    <= '0;
            lane       <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            locked     <= 1'b0;
            sync_err   <= 1'b0;
            fcnt       <= '0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            word_valid <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (take) begin
                lane[slot[1:0]] <= din;
            end
            if (din_valid) begin
                case (state)
                    HUNT: begin
                        if (sync) begin
                            state   <= LOCKED;
                            locked  <= 1'b1;
                            address <= ADDR_W'(1);
                            fcnt    <= '0;
                        end
                    end
                    LOCKED: begin
                        if (early) begin
                            sync_err <= 1'b1;
                            address  <= ADDR_W'(1);
                            fcnt     <= '0;
                        end else if (missing) begin
                            sync_err <= 1'b1;
                            state    <= HUNT;
                            locked   <= 1'b0;
                            address  <= '0;
                            fcnt     <= '0;
                        end else begin
`ifdef TDM_DEMUX_PARITY_EN
                            // lane holds slots 0..3 of this frame when the parity slot arrives
                            if (address == ADDR_W'(LANES) && ((^lane) != din)) begin
                                parity_err <= 1'b1;
                            end
`endif
                            if (address == LAST_SLOT) begin
                                address <= '0;
                                if (fcnt == CW'(WIDTH - 1)) begin
                                    word       <= word_nxt;
                                    word_valid <= 1'b1;
                                    fcnt       <= '0;
                                end else begin
                                    fcnt <= fcnt + CW'(1);
                                end
                            end else begin
                                address <= address + ADDR_W'(1);
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: vector table, directed corner sequences,
// and randomized beats compared against a queue-based frame model.
module tb_tdm_demux4;

    localparam int W = 8;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int NS = 5;
`else
    localparam int NS = 4;
`endif

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           din = 1'b0;
    logic           din_valid = 1'b0;
    logic           sync = 1'b0;
    logic [2:0]     address;
    logic [3:0]     lane;
    logic [4*W-1:0] word;
    logic           word_valid;
    logic           locked;
    logic           sync_err;
`ifdef TDM_DEMUX_PARITY_EN
    logic           parity_err;
`endif

    int checks = 0;
    int errors = 0;
    int wv_seen = 0;

    // reference model state
    bit             m_locked;
    int             m_addr;
    int             m_frames;
    logic [3:0]     m_lane;
    bit             m_q [4][$];
    logic [4*W-1:0] m_word;
    bit             m_wv;
    bit             m_serr;
    bit             m_perr;

    localparam logic [4*W-1:0] PAT1 = 32'h00FF3CA5;
    localparam logic [4*W-1:0] PAT2 = 32'h7E81C35A;

    tdm_demux4 #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .sync       (sync),
        .address    (address),
        .lane       (lane),
        .word       (word),
        .word_valid (word_valid),
        .locked     (locked),
`ifdef TDM_DEMUX_PARITY_EN
        .parity_err (parity_err),
`endif
        .sync_err   (sync_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_clear_q();
        for (int k = 0; k < 4; k++) m_q[k].delete();
    endtask

    task automatic m_reset();
        m_locked = 0; m_addr = 0; m_frames = 0; m_lane = '0;
        m_word = '0; m_wv = 0; m_serr = 0; m_perr = 0;
        m_clear_q();
    endtask

    task automatic m_start_frame(input bit d);
        m_clear_q();
        m_q[0].push_back(d);
        m_lane[0] = d;
        m_addr = 1;
        m_frames = 0;
    endtask

    task automatic m_step(input bit v, input bit s, input bit d);
        logic [W-1:0] val;
        m_wv = 0;
        m_perr = 0;
        if (!v) return;
        if (!m_locked) begin
            if (s) begin
                m_locked = 1;
                m_start_frame(d);
            end
            return;
        end
        if (s && m_addr != 0) begin
            m_serr = 1;
            m_start_frame(d);
            return;
        end
        if (!s && m_addr == 0) begin
            m_serr = 1;
            m_locked = 0;
            m_addr = 0;
            m_frames = 0;
            m_clear_q();
            return;
        end
        if (m_addr < 4) begin
            m_lane[m_addr] = d;
            m_q[m_addr].push_back(d);
        end else if ((^m_lane) != d) begin
            m_perr = 1;
        end
        if (m_addr == NS - 1) begin
            m_addr = 0;
            m_frames++;
            if (m_frames == W) begin
                for (int k = 0; k < 4; k++) begin
                    val = '0;
                    foreach (m_q[k][j]) val = {val[W-2:0], m_q[k][j]};
                    m_word[k*W +: W] = val;
                end
                m_wv = 1;
                m_frames = 0;
                m_clear_q();
            end
        end else begin
            m_addr++;
        end
    endtask

    task automatic check_all();
        chk("addr", 64'(address), 64'(m_addr));
        chk("lane", 64'(lane), 64'(m_lane));
        chk("locked", 64'(locked), 64'(m_locked));
        chk("sync_err", 64'(sync_err), 64'(m_serr));
        chk("word_valid", 64'(word_valid), 64'(m_wv));
        chk("word", 64'(word), 64'(m_word));
`ifdef TDM_DEMUX_PARITY_EN
        chk("parity_err", 64'(parity_err), 64'(m_perr));
`endif
    endtask

    task automatic beat(input bit d, input bit v, input bit s);
        @(negedge clock);
        din = d; din_valid = v; sync = s;
        @(posedge clock);
        m_step(v, s, d);
        #1;
        if (word_valid) wv_seen++;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; din_valid = 1'b0; sync = 1'b0;
        m_reset();
        #2;
        check_all();
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Stream bit i of a word pattern: frame i/NS, slot i%NS, MSB of each lane first.
    function automatic bit sbit(input logic [4*W-1:0] pat, input int i);
        int f;
        int k;
        bit p;
        f = i / NS;
        k = i % NS;
        if (k < 4) return pat[k*W + (W-1-f)];
        p = 0;
        for (int j = 0; j < 4; j++) p ^= pat[j*W + (W-1-f)];
        return p;
    endfunction

    task automatic send(input logic [4*W-1:0] pat, input int first, input int last, input bit idle);
        for (int i = first; i < last; i++) begin
            if (idle) beat(1'($urandom), 1'b0, 1'($urandom));
            beat(sbit(pat, i), 1'b1, (i % NS) == 0);
        end
    endtask

    typedef struct {
        bit         v;
        bit         s;
        bit         d;
        logic [2:0] ea;
        logic [3:0] el;
        bit         elk;
    } vec_t;

    initial begin
        vec_t tv [6];
        int   n0;
        bit   s;

        tv[0] = '{v:1, s:0, d:1, ea:3'd0, el:4'b0000, elk:0};
        tv[1] = '{v:1, s:1, d:1, ea:3'd1, el:4'b0001, elk:1};
        tv[2] = '{v:0, s:0, d:0, ea:3'd1, el:4'b0001, elk:1};
        tv[3] = '{v:1, s:0, d:0, ea:3'd2, el:4'b0001, elk:1};
        tv[4] = '{v:1, s:0, d:1, ea:3'd3, el:4'b0101, elk:1};
        tv[5] = '{v:1, s:0, d:1, ea:(NS == 4) ? 3'd0 : 3'd4, el:4'b1101, elk:1};

        m_reset();
        reset = 1'b1;
        #12;
        chk("rst_addr", 64'(address), 64'd0);
        chk("rst_lane", 64'(lane), 64'd0);
        chk("rst_word", 64'(word), 64'd0);
        chk("rst_wv", 64'(word_valid), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_serr", 64'(sync_err), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            beat(tv[i].d, tv[i].v, tv[i].s);
            chk("tv_addr", 64'(address), 64'(tv[i].ea));
            chk("tv_lane", 64'(lane), 64'(tv[i].el));
            chk("tv_locked", 64'(locked), 64'(tv[i].elk));
            chk("tv_wv", 64'(word_valid), 64'd0);
        end

        // eight aligned frames
        do_reset();
        n0 = wv_seen;
        send(PAT1, 0, NS*W, 1'b0);
        chk("w_word", 64'(word), 64'h00FF3CA5);
        chk("w_vld", 64'(word_valid), 64'd1);
        beat(1'b0, 1'b0, 1'b0);
        chk("w_pulse_end", 64'(word_valid), 64'd0);
        chk("w_count", 64'(wv_seen - n0), 64'd1);

        // same stream with idle cycles interleaved
        do_reset();
        n0 = wv_seen;
        send(PAT1, 0, NS*W, 1'b1);
        chk("gap_word", 64'(word), 64'h00FF3CA5);
        beat(1'b0, 1'b0, 1'b0);
        chk("gap_count", 64'(wv_seen - n0), 64'd1);

        // early sync at address 2
        do_reset();
        send(PAT1, 0, NS + 2, 1'b0);
        chk("es_pre_addr", 64'(address), 64'd2);
        beat(sbit(PAT2, 0), 1'b1, 1'b1);
        chk("es_serr", 64'(sync_err), 64'd1);
        chk("es_addr", 64'(address), 64'd1);
        chk("es_locked", 64'(locked), 64'd1);
        send(PAT2, 1, NS*W, 1'b0);
        chk("es_word", 64'(word), 64'h7E81C35A);
        chk("es_wv", 64'(word_valid), 64'd1);
        chk("es_serr_sticky", 64'(sync_err), 64'd1);

        // missing sync at address 0
        do_reset();
        send(PAT1, 0, NS, 1'b0);
        beat(1'b1, 1'b1, 1'b0);
        chk("ms_serr", 64'(sync_err), 64'd1);
        chk("ms_locked", 64'(locked), 64'd0);
        chk("ms_addr", 64'(address), 64'd0);
        for (int i = 0; i < 5; i++) begin
            beat(1'($urandom), 1'b1, 1'b0);
            chk("ms_hunt_addr", 64'(address), 64'd0);
            chk("ms_hunt_locked", 64'(locked), 64'd0);
        end
        beat(1'b1, 1'b1, 1'b1);
        chk("ms_relock", 64'(locked), 64'd1);
        chk("ms_relock_addr", 64'(address), 64'd1);

        // asynchronous reset one beat before completion
        do_reset();
        n0 = wv_seen;
        send(PAT1, 0, NS*W - 1, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        m_reset();
        #1;
        chk("ar_addr", 64'(address), 64'd0);
        chk("ar_locked", 64'(locked), 64'd0);
        chk("ar_word", 64'(word), 64'd0);
        chk("ar_lane", 64'(lane), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        beat(sbit(PAT1, NS*W - 1), 1'b1, 1'b0);
        beat(1'b0, 1'b0, 1'b0);
        chk("ar_no_word", 64'(wv_seen - n0), 64'd0);

`ifdef TDM_DEMUX_PARITY_EN
        do_reset();
        beat(1'b1, 1'b1, 1'b1);
        beat(1'b1, 1'b1, 1'b0);
        beat(1'b0, 1'b1, 1'b0);
        beat(1'b0, 1'b1, 1'b0);
        beat(1'b1, 1'b1, 1'b0);
        chk("par_bad", 64'(parity_err), 64'd1);
        beat(1'b0, 1'b0, 1'b0);
        chk("par_pulse_end", 64'(parity_err), 64'd0);
        beat(1'b1, 1'b1, 1'b1);
        beat(1'b1, 1'b1, 1'b0);
        beat(1'b0, 1'b1, 1'b0);
        beat(1'b0, 1'b1, 1'b0);
        beat(1'b0, 1'b1, 1'b0);
        chk("par_good", 64'(parity_err), 64'd0);
`endif

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if (m_locked) s = (m_addr == 0);
            else s = ($urandom % 3) == 0;
            if (($urandom % 40) == 0) s = !s;
            beat(1'($urandom), ($urandom % 4) != 0, s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
